// File: rtl/snitch_perf_counters_if.sv
// snitch_perf_counters_if: 32-bit register request/response port of the cluster
// performance-counter unit.
//   req_valid/req_write/req_addr/req_wdata : request, driven by the master
//   req_ready                              : request accepted (slave)
//   rsp_valid/rsp_rdata/rsp_err            : one-cycle-later response (slave)
interface snitch_perf_counters_if #(
   parameter int unsigned AddrWidth = 4
);
   logic                 req_valid;
   logic                 req_write;
   logic [AddrWidth-1:0] req_addr;
   logic [31:0]          req_wdata;
   logic                 req_ready;
   logic                 rsp_valid;
   logic [31:0]          rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/snitch_perf_counters.sv
// snitch_perf_counters: cluster performance-counter unit. Samples NumEvents strobes
// from each of NumCores harts and accumulates them into NumCounters counters of
// CounterWidth bits, each tracking one hart's event or the popcount over all harts.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   events_i      : hart h, event e at bit h*NumEvents+e
//   freeze_i      : halts all counting while high
//   bus_io        : register port, word address {counter index, reg sel}
//                   sel 0 CFG, 1 CNT_LO, 2 CNT_HI, 3 STATUS
//   irq_o         : registered OR of (ovf & irq_en) over all counters
module snitch_perf_counters #(
   parameter int unsigned NumCores     = 8,
   parameter int unsigned NumCounters  = 4,
   parameter int unsigned CounterWidth = 48,
   parameter int unsigned NumEvents    = 7
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumCores*NumEvents-1:0] events_i,
   input  logic                          freeze_i,
   snitch_perf_counters_if.slave         bus_io,
   output logic                          irq_o
);
   localparam int unsigned IdxWidth = (NumCounters > 1) ? $clog2(NumCounters) : 1;
   localparam int unsigned IncWidth = $clog2(NumCores + 1);
   localparam int unsigned HiWidth  = CounterWidth - 32;
   localparam int unsigned SumWidth = CounterWidth + 1;
   // CFG bits that exist: en, mode, irq_en, event_sel, hart_sel.
   localparam logic [15:0] CfgMask  = 16'hFFF7;

   logic [IdxWidth-1:0] req_idx;
   logic [1:0]          req_sel;
   logic                idx_valid;

   assign req_idx   = IdxWidth'(bus_io.req_addr >> 2);
   assign req_sel   = bus_io.req_addr[1:0];
   assign idx_valid = (32'(bus_io.req_addr >> 2) < NumCounters);

   logic [NumCounters-1:0][15:0]             cfg_all;
   logic [NumCounters-1:0][CounterWidth-1:0] cnt_all;
   logic [NumCounters-1:0]                   ovf_all;
   logic [NumCounters-1:0]                   irq_en_all;

   for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
      logic [15:0]             cfg_q, cfg_d;
      logic [CounterWidth-1:0] cnt_q, cnt_d;
      logic                    ovf_q, ovf_d;
      logic [NumEvents-1:0]    ev_onehot;
      logic [NumCores-1:0]     hart_onehot;
      logic [NumCores-1:0]     hv;
      logic [IncWidth-1:0]     inc;
      logic [SumWidth-1:0]     sum;
      logic                    wr;

      // Shifts past the vector width give an all-zero mask, so out-of-range
      // event_sel / hart_sel select nothing and the increment is 0.
      assign ev_onehot   = NumEvents'(1) << cfg_q[7:4];
      assign hart_onehot = NumCores'(1) << cfg_q[15:8];

      for (genvar h = 0; h < NumCores; h++) begin : g_hart
         assign hv[h] = |(events_i[h*NumEvents +: NumEvents] & ev_onehot);
      end

      always_comb begin
         inc = '0;
         if (cfg_q[0] && !freeze_i) begin
            inc = cfg_q[1] ? IncWidth'($countones(hv)) : IncWidth'(|(hv & hart_onehot));
         end
         sum = {1'b0, cnt_q} + SumWidth'(inc);
         wr  = bus_io.req_valid & bus_io.req_write & idx_valid & (req_idx == IdxWidth'(i));

         cfg_d = cfg_q;
         cnt_d = sum[CounterWidth-1:0];
         ovf_d = ovf_q;
         if (wr && req_sel == 2'd0) cfg_d = bus_io.req_wdata[15:0] & CfgMask;
         if (wr && req_sel == 2'd3 && bus_io.req_wdata[0]) ovf_d = 1'b0;
         // A half write replaces the whole increment: no carry into the other half.
         if (wr && req_sel == 2'd1) begin
            cnt_d = {cnt_q[CounterWidth-1:32], bus_io.req_wdata};
         end else if (wr && req_sel == 2'd2) begin
            cnt_d = {bus_io.req_wdata[HiWidth-1:0], cnt_q[31:0]};
         end else if (sum[CounterWidth]) begin
            ovf_d = 1'b1;  // overflow beats a same-cycle clear
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cfg_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end

      assign cfg_all[i]    = cfg_q;
      assign cnt_all[i]    = cnt_q;
      assign ovf_all[i]    = ovf_q;
      assign irq_en_all[i] = cfg_q[2];
   end

   logic [31:0] rdata_d, rdata_q;
   logic        valid_q, err_q, irq_q;

   always_comb begin
      rdata_d = '0;
      if (bus_io.req_valid && !bus_io.req_write && idx_valid) begin
         case (req_sel)
            2'd0:    rdata_d = {16'h0, cfg_all[req_idx]};
            2'd1:    rdata_d = cnt_all[req_idx][31:0];
            2'd2:    rdata_d = 32'(cnt_all[req_idx][CounterWidth-1:32]);
            default: rdata_d = {31'h0, ovf_all[req_idx]};
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         valid_q <= bus_io.req_valid;
         rdata_q <= rdata_d;
         err_q   <= bus_io.req_valid & ~idx_valid;
         irq_q   <= |(ovf_all & irq_en_all);
      end
   end

   assign bus_io.req_ready = 1'b1;
   assign bus_io.rsp_valid = valid_q;
   assign bus_io.rsp_rdata = rdata_q;
   assign bus_io.rsp_err   = err_q;
   assign irq_o            = irq_q;
endmodule

// File: doc/snitch_perf_counters.md
# snitch_perf_counters

Parametrised cluster performance-counter unit: generalised successor of the fixed per-core `core_events_t` strobe set. Samples the event strobes of `NumCores` harts and accumulates them into `NumCounters` independently configurable counters of `CounterWidth` bits. Each counter can track one hart's event or the population count across all harts. Counters have sticky overflow and a maskable interrupt. The unit sits in the cluster peripherals behind a 32-bit register request/response port.

## Interface
- `NumCores`, 8: harts observed; 1..256.
- `NumCounters`, 4: counters; 1..16.
- `CounterWidth`, 48: counter bits; 33..64.
- `NumEvents`, 7: strobes per hart; equals the bit count of `core_events_t`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `events_i` in NumCores*NumEvents: hart h, event e at bit h*NumEvents+e; packed `core_events_t` order (bit 0 = retired_acc, bit 6 = issue_fpu).
- `freeze_i` in 1: halts all counting while high.
- `req_valid_i` in 1: register access request.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in $clog2(NumCounters)+2: word address {counter index, reg sel}.
- `req_wdata_i` in 32: write data.
- `req_ready_o` out 1: constant 1; every valid request is accepted in its cycle.
- `rsp_valid_o` out 1: response strobe.
- `rsp_rdata_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: counter index ≥ NumCounters.
- `irq_o` out 1: registered overflow interrupt.

## Operation
- Per counter i, reg sel: 0 CFG, 1 CNT_LO (bits 31:0), 2 CNT_HI (bits CounterWidth-1:32, zero-extended), 3 STATUS.
- CFG: bit0 `en`, bit1 `mode` (0 single hart, 1 all harts), bit2 `irq_en`, bits 7:4 `event_sel`, bits 15:8 `hart_sel`; other bits read 0, writes ignored.
- Increment per cycle when `en` & !`freeze_i`:
  - mode 0: 1 if `events_i[hart_sel*NumEvents+event_sel]`, else 0;
  - mode 1: popcount of event `event_sel` over all harts (0..NumCores);
  - `event_sel` ≥ NumEvents or, in mode 0, `hart_sel` ≥ NumCores: increment 0.
- Addition modulo 2^CounterWidth. A carry out sets sticky STATUS bit0 `ovf`.
- STATUS write: bit0 = 1 clears `ovf`; a same-cycle overflow wins (ovf stays 1).
- CNT_LO/CNT_HI write: loads that half. The write replaces that cycle's increment for the whole counter; the other half keeps its pre-increment value, so there is no carry into the unwritten half.
- CFG write takes effect from the next cycle; the current cycle counts with the old config.
- Invalid index (index ≥ NumCounters): read returns 0, write ignored, `rsp_err_o` = 1.
- `irq_o` = registered OR over i of (`ovf[i]` & `irq_en[i]`).

## Timing
- Reset: all CFG, counters and `ovf` = 0. Outputs: `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o` and `irq_o` = 0; `req_ready_o` = 1.
- An event high in cycle t is visible in CNT reads issued at t+1 or later.
- Read latency 1: request at t gives `rsp_valid_o`/`rsp_rdata_o` at t+1. Read data is the register value at the start of t, before that cycle's update.
- Writes: `rsp_valid_o` at t+1; the write is effective at the t→t+1 edge.
- Reading a full counter takes two reads and is non-atomic; software freezes via `freeze_i`, or reads HI-LO-HI.
- `ovf` is set at the edge ending the overflowing cycle; `irq_o` rises one cycle later.
- Reset asserted mid-operation clears everything asynchronously. A response in flight is dropped: `rsp_valid_o` = 0 while reset is low.

## Test plan
- Reset, then read all regs of counter 0 -> every `rsp_rdata_o` = 0 at t+1, `irq_o` = 0.
- CFG0 = 0x0301 (hart 3, event 0, mode 0, en); pulse hart 3 bit 0 for 5 cycles and hart 2 bit 0 for 5 cycles -> CNT_LO = 5.
- CFG1 = 0x0063 (event 6, mode 1, en); all 8 harts assert issue_fpu for 10 cycles -> CNT_LO = 80. With `freeze_i` high for the last 4 cycles -> CNT_LO = 48.
- Load CNT_HI = 0xFFFF and CNT_LO = 0xFFFFFFFE on counter 2 (48-bit, mode 1, `irq_en`); 3 harts strobe once -> counter = 1, `ovf` = 1, `irq_o` = 1 two cycles after the strobe. STATUS write 1 -> `irq_o` = 0.
- Same-cycle STATUS clear and overflow -> `ovf` stays 1. Same-cycle CNT_LO write 0x10 and event -> CNT_LO = 0x10.
- NumCounters = 3: read index 3 -> data 0, `rsp_err_o` = 1. Reset asserted mid-count -> counter and `rsp_valid_o` = 0 immediately.
